csa_seq_arb: RTL

CSA_SEQ_ARB -- requirements
Module: csa_seq_arb

---
 rtl/csa_seq_pkg.sv | 7 +
 rtl/csa_slice.sv | 18 +
 rtl/csa_seq_arb.sv | 89 ++++++++
 3 files changed

// File: rtl/csa_seq_pkg.sv
// csa_seq_pkg: shared FSM state, requester id type and default widths for csa_seq_arb.
package csa_seq_pkg;
  localparam int WIDTH_DEF = 40;
  localparam int SLICE_DEF = 10;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic req_id_t;
endpackage

// File: rtl/csa_slice.sv
// csa_slice: combinational carry-select adder slice; both carry-in cases are
// summed in parallel and the real carry-in picks one.
module csa_slice
  import csa_seq_pkg::*;
#(
  parameter int W = SLICE_DEF
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);
  logic [W:0] w_s0, w_s1;
  assign w_s0 = {1'b0, i_a} + {1'b0, i_b};
  assign w_s1 = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, 1'b1};
  assign {o_cout, o_sum} = i_cin ? w_s1 : w_s0;
endmodule

// File: rtl/csa_seq_arb.sv
// csa_seq_arb: two-requester round-robin front end feeding one SLICE-bit adder
// that builds a WIDTH-bit sum over WIDTH/SLICE cycles. CSA_SEQ_SAT_EN saturates on carry out.
module csa_seq_arb
  import csa_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  input  logic             i_req1_valid,
  output logic             o_req0_ready,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_sum,
  output logic             o_res_cout,
  output logic             o_res_id
);
  localparam int NCHUNK = WIDTH / SLICE;
  localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [KW-1:0] r_k;
  logic r_carry;
  req_id_t r_id, r_last;
  logic w_g0, w_g1, w_grant, w_cout;
  logic [SLICE-1:0] w_s;
  // r_last names the previous winner, so a tie goes to the other requester
  assign w_g0 = r_state == IDLE && i_rst_n && i_req0_valid && (!i_req1_valid || r_last);
  assign w_g1 = r_state == IDLE && i_rst_n && i_req1_valid && (!i_req0_valid || !r_last);
  assign w_grant = w_g0 | w_g1;
  csa_slice #(.W(SLICE)) u_slice (
    .i_a   (r_a[r_k*SLICE +: SLICE]),
    .i_b   (r_b[r_k*SLICE +: SLICE]),
    .i_cin (r_carry),
    .o_sum (w_s),
    .o_cout(w_cout)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    o_req0_ready = w_g0;
    o_req1_ready = w_g1;
    o_res_valid = r_state == DONE;
    unique case (r_state)
      IDLE: w_next = w_grant ? RUN : IDLE;
      RUN: w_next = r_k == KLAST ? DONE : RUN;
      DONE: w_next = i_res_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_sum <= '0;
      r_k <= '0;
      r_carry <= 1'b0;
      r_id <= 1'b0;
      r_last <= 1'b1;
    end else if (w_grant) begin
      r_a <= w_g1 ? i_req1_a : i_req0_a;
      r_b <= w_g1 ? i_req1_b : i_req0_b;
      r_id <= w_g1;
      r_last <= w_g1;
      r_carry <= 1'b0;
      r_k <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_k*SLICE +: SLICE] <= w_s;
      r_carry <= w_cout;
      r_k <= r_k == KLAST ? '0 : r_k + 1'b1;
    end
  assign o_res_cout = r_carry;
  assign o_res_id = r_id;
`ifdef CSA_SEQ_SAT_EN
  assign o_res_sum = r_carry ? '1 : r_sum;
`else
  assign o_res_sum = r_sum;
`endif
endmodule
